imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 35 +++
 rtl/imem_arbiter_instruction_regfile.sv | 37 +++
 rtl/imem_arbiter.sv | 141 ++++++++++++++
 tb/tb_imem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: default geometry,
// the memory-operation kind issued each cycle, and the packed fetch-address
// slice helper used to pick one SM's address out of the flat port bus.
package imem_arbiter_pkg;

  localparam int NUM_SM_DEF       = 4;
  localparam int ADDR_W_DEF       = 5;
  localparam int DATA_W_DEF       = 16;
  localparam int WR_BURST_MAX_DEF = 4;

  // Upper bounds accepted by addr_slice; the flat fetch-address bus is
  // zero-extended to SLICE_VEC_MAX bits before slicing.
  localparam int SLICE_VEC_MAX  = 256;
  localparam int SLICE_ADDR_MAX = 16;

  // The single memory operation issued in a given cycle.
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FETCH = 2'd2
  } mem_op_e;

  // Return the aw-bit address of requester idx from a packed bus where
  // requester i occupies bits [i*aw +: aw]. Bits above aw are zero.
  function automatic logic [SLICE_ADDR_MAX-1:0] addr_slice(
    input logic [SLICE_VEC_MAX-1:0] vec,
    input int                       idx,
    input int                       aw
  );
    logic [SLICE_ADDR_MAX-1:0] ones;
    ones = '1;
    return SLICE_ADDR_MAX'(vec >> (idx * aw)) & ~(ones << aw);
  endfunction

endpackage

// File: rtl/imem_arbiter_instruction_regfile.sv
// Instruction storage: one synchronous write port, one combinational read
// port driven from an externally registered address. Contents clear on reset.
module instruction_regfile
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage update: clear everything on reset, otherwise commit one write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read path is purely combinational from the registered address, so a
  // word written on one edge is visible to a read launched on that edge.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-ported instruction regfile
// between a host write port and NUM_SM fetch ports. One operation per cycle;
// the host wins unless it has already taken WR_BURST_MAX consecutive slots
// while fetches waited. Fetches are served round-robin with one-cycle latency.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int NUM_SM       = NUM_SM_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WR_BURST_MAX = WR_BURST_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_wr_req,
  input  logic [ADDR_W-1:0]        host_wr_addr,
  input  logic [DATA_W-1:0]        host_wr_data,
  output logic                     host_wr_ack,
  input  logic [NUM_SM-1:0]        fetch_req,
  input  logic [NUM_SM*ADDR_W-1:0] fetch_addr,
  output logic [NUM_SM-1:0]        fetch_gnt,
  output logic [NUM_SM-1:0]        fetch_valid,
  output logic [DATA_W-1:0]        fetch_data,
  output logic                     busy
);

  localparam int PTR_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;
  localparam int RUN_W = $clog2(WR_BURST_MAX + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SM - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(WR_BURST_MAX);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  // Arbitration state
  logic [PTR_W-1:0]  rr_ptr;
  logic [RUN_W-1:0]  wr_run;

  // Arbitration decision for the current cycle
  mem_op_e           op_sel;
  logic              fetch_any;
  logic              wr_stall;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;
  logic [ADDR_W-1:0] gnt_addr;

  // Read pipeline
  logic [NUM_SM-1:0] vld_p1;
  logic [ADDR_W-1:0] rd_addr_p1;
  logic [DATA_W-1:0] rd_data;

  assign fetch_any = |fetch_req;

  // Fairness guard: once the host has taken WR_BURST_MAX slots in a row
  // with a fetch waiting, the next slot is forced to a fetch.
  assign wr_stall = fetch_any && (wr_run == RUN_MAX);

  // Pick this cycle's single memory operation and drive grant/ack.
  always_comb begin
    op_sel      = OP_NONE;
    host_wr_ack = 1'b0;
    fetch_gnt   = '0;
    gnt_idx     = '0;
    cand_idx    = '0;
    cand        = 0;
    gnt_addr    = '0;
    if (!rst) begin
      if (host_wr_req && !wr_stall) begin
        op_sel      = OP_WRITE;
        host_wr_ack = 1'b1;
      end else if (fetch_any) begin
        op_sel = OP_FETCH;
        // Walk from farthest to nearest so the requester closest to rr_ptr
        // (searching upward with wrap) is the last, and winning, assignment.
        for (int k = NUM_SM - 1; k >= 0; k--) begin
          cand = int'(rr_ptr) + k;
          if (cand >= NUM_SM) begin
            cand = cand - NUM_SM;
          end
          cand_idx = PTR_W'(cand);
          if (fetch_req[cand_idx]) begin
            gnt_idx = cand_idx;
          end
        end
        fetch_gnt[gnt_idx] = 1'b1;
        gnt_addr = ADDR_W'(addr_slice(SLICE_VEC_MAX'(fetch_addr), int'(gnt_idx), ADDR_W));
      end
    end
  end

  // ---- stage p0 -> p1: launch the granted read ----
  // Read address is datapath only; fetch_valid qualifies it, so no reset.
  always_ff @(posedge clk) begin
    if (op_sel == OP_FETCH) begin
      rd_addr_p1 <= gnt_addr;
    end
  end

  // Control state: read owner, round-robin pointer and write-burst counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
      rr_ptr <= '0;
      wr_run <= '0;
    end else begin
      vld_p1 <= fetch_gnt;
      if (op_sel == OP_FETCH) begin
        rr_ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_ONE;
      end
      if (!fetch_any || op_sel == OP_FETCH) begin
        wr_run <= '0;
      end else if (op_sel == OP_WRITE && wr_run != RUN_MAX) begin
        wr_run <= wr_run + RUN_ONE;
      end
    end
  end

  instruction_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (host_wr_ack),
    .wr_addr (host_wr_addr),
    .wr_data (host_wr_data),
    .rd_addr (rd_addr_p1),
    .rd_data (rd_data)
  );

  // ---- stage p1: return data ----
  // Outputs are forced quiet while rst is high, including the first reset
  // cycle when the registered read owner may still be set.
  always_comb begin
    fetch_valid = rst ? '0 : vld_p1;
    fetch_data  = (!rst && (|vld_p1)) ? rd_data : '0;
    busy        = !rst && (host_wr_req || fetch_any || (|vld_p1));
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter. Stimulus pushes expected issue events
// (write ack / fetch grant) and read responses, tagged with the cycle they
// must appear in; a negedge monitor pops and compares whatever the DUT shows.
module tb_imem_arbiter;

  localparam int NUM_SM = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     host_wr_req;
  logic [ADDR_W-1:0]        host_wr_addr;
  logic [DATA_W-1:0]        host_wr_data;
  logic                     host_wr_ack;
  logic [NUM_SM-1:0]        fetch_req;
  logic [NUM_SM*ADDR_W-1:0] fetch_addr;
  logic [NUM_SM-1:0]        fetch_gnt;
  logic [NUM_SM-1:0]        fetch_valid;
  logic [DATA_W-1:0]        fetch_data;
  logic                     busy;

  imem_arbiter #(
    .NUM_SM       (NUM_SM),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .WR_BURST_MAX (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host_wr_req  (host_wr_req),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ack  (host_wr_ack),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit is_wr; int sm; } iss_t;
  typedef struct { int cyc; int sm; logic [DATA_W-1:0] data; } rsp_t;

  iss_t q_iss[$];
  rsp_t q_rsp[$];
  iss_t ie;
  rsp_t re;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NUM_SM-1:0] oh(input int sm);
    logic [NUM_SM-1:0] one;
    one = 1;
    return one << sm;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_iss(input int c, input bit is_wr, input int sm);
    q_iss.push_back('{c, is_wr, sm});
  endtask

  task automatic exp_rsp(input int c, input int sm, input logic [DATA_W-1:0] d);
    q_rsp.push_back('{c, sm, d});
  endtask

  task automatic set_addr(input int sm, input int a);
    fetch_addr[sm*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    host_wr_req  = 1'b1;
    host_wr_addr = ADDR_W'(a);
    host_wr_data = d;
    exp_iss(cyc, 1'b1, 0);
    step();
    host_wr_req = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack"},   64'(host_wr_ack), 64'(0));
    check({tag, "_gnt"},   64'(fetch_gnt),   64'(0));
    check({tag, "_valid"}, 64'(fetch_valid), 64'(0));
    check({tag, "_data"},  64'(fetch_data),  64'(0));
    check({tag, "_busy"},  64'(busy),        64'(0));
  endtask

  // Monitor: match every ack/grant and every valid against the scoreboard.
  always @(negedge clk) begin
    while (q_iss.size() > 0 && q_iss[0].cyc < cyc) begin
      ie = q_iss.pop_front();
      n_chk++; n_fail++;
      $display("FAIL issue_missing: nothing seen, required wr=%0d sm=%0d at cycle %0d", ie.is_wr, ie.sm, ie.cyc);
    end
    if (host_wr_ack || fetch_gnt != '0) begin
      if (q_iss.size() == 0 || q_iss[0].cyc != cyc) begin
        n_chk++; n_fail++;
        $display("FAIL issue_unexpected: got ack=%0b gnt=%b, required none at cycle %0d", host_wr_ack, fetch_gnt, cyc);
      end else begin
        ie = q_iss.pop_front();
        check("issue", 64'({host_wr_ack, fetch_gnt}),
              ie.is_wr ? 64'({1'b1, 4'b0000}) : 64'({1'b0, oh(ie.sm)}));
      end
    end
    while (q_rsp.size() > 0 && q_rsp[0].cyc < cyc) begin
      re = q_rsp.pop_front();
      n_chk++; n_fail++;
      $display("FAIL resp_missing: nothing seen, required sm=%0d data=%h at cycle %0d", re.sm, re.data, re.cyc);
    end
    if (fetch_valid != '0) begin
      if (q_rsp.size() == 0 || q_rsp[0].cyc != cyc) begin
        n_chk++; n_fail++;
        $display("FAIL resp_unexpected: got valid=%b data=%h, required none at cycle %0d", fetch_valid, fetch_data, cyc);
      end else begin
        re = q_rsp.pop_front();
        check("resp", 64'({fetch_valid, fetch_data}), 64'({oh(re.sm), re.data}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every requester active: nothing may be issued.
    rst = 1'b1; host_wr_req = 1'b1; host_wr_addr = '0; host_wr_data = 16'hFFFF;
    fetch_req = 4'hF; fetch_addr = '0;
    step();
    @(negedge clk); check_quiet("reset");
    step();
    @(negedge clk);
    check("reset_rr_ptr", 64'(dut.rr_ptr), 64'(0));
    check("reset_wr_run", 64'(dut.wr_run), 64'(0));
    step();
    rst = 1'b0; host_wr_req = 1'b0; fetch_req = '0;
    step();

    // Single fetch with one-cycle latency.
    wr(3, 16'hA5A5);
    fetch_req = 4'b0100; set_addr(2, 3);
    exp_iss(cyc, 1'b0, 2); exp_rsp(cyc + 1, 2, 16'hA5A5);
    @(negedge clk); check("busy_pending", 64'(busy), 64'(1));
    step(); fetch_req = '0;
    step();

    // Write then fetch same address on the next cycle.
    wr(7, 16'h1234);
    fetch_req = 4'b0001; set_addr(0, 7);
    exp_iss(cyc, 1'b0, 0); exp_rsp(cyc + 1, 0, 16'h1234);
    step(); fetch_req = '0;
    step();

    // SM3 withdraws while the host holds the slot; SM0 alone is granted.
    host_wr_req = 1'b1; host_wr_addr = 5'd9; host_wr_data = 16'hBEEF;
    fetch_req = 4'b1001; set_addr(0, 3); set_addr(3, 7);
    exp_iss(cyc, 1'b1, 0);
    step();
    host_wr_req = 1'b0; fetch_req = 4'b0001;
    exp_iss(cyc, 1'b0, 0); exp_rsp(cyc + 1, 0, 16'hA5A5);
    step(); fetch_req = '0;
    @(negedge clk);
    check("withdraw_rr_ptr", 64'(dut.rr_ptr), 64'(1));
    check("withdraw_wr_run", 64'(dut.wr_run), 64'(0));
    step();

    // Reset on the cycle after a grant discards the read.
    fetch_req = 4'b0010; set_addr(1, 3);
    exp_iss(cyc, 1'b0, 1);
    step();
    rst = 1'b1; fetch_req = '0;
    @(negedge clk); check_quiet("rst_inflight");
    step();
    fetch_req = 4'hF; set_addr(0, 3); set_addr(1, 7); set_addr(2, 3); set_addr(3, 9);
    @(negedge clk); check_quiet("rst_hold");
    check("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
    check("rst_wr_run", 64'(dut.wr_run), 64'(0));
    step();

    // All four request from reset: grants 0,1,2,3,0; memory was cleared.
    rst = 1'b0;
    base = cyc;
    for (int k = 0; k < 5; k++) begin
      exp_iss(base + k, 1'b0, k % 4);
      exp_rsp(base + k + 1, k % 4, 16'h0000);
    end
    for (int k = 0; k < 5; k++) step();
    fetch_req = '0;
    step();

    // Host writes continuously while SM1 waits: 4 acks, grant, acks resume.
    set_addr(1, 20);
    base = cyc;
    for (int k = 0; k < 4; k++) exp_iss(base + k, 1'b1, 0);
    exp_iss(base + 4, 1'b0, 1);
    exp_rsp(base + 5, 1, 16'h5003);
    exp_iss(base + 5, 1'b1, 0);
    exp_iss(base + 6, 1'b1, 0);
    for (int k = 0; k < 7; k++) begin
      host_wr_req  = 1'b1;
      host_wr_addr = 5'd20;
      host_wr_data = 16'h5000 + 16'(k);
      fetch_req    = (k <= 4) ? 4'b0010 : 4'b0000;
      if (k == 4) begin
        @(negedge clk); check("burst_wr_run_sat", 64'(dut.wr_run), 64'(4));
      end
      step();
    end
    host_wr_req = 1'b0;
    @(negedge clk); check("burst_wr_run_clear", 64'(dut.wr_run), 64'(0));
    step();

    // Back-to-back fetches from one SM, eligible while its valid is high.
    fetch_req = 4'b0100; set_addr(2, 20);
    exp_iss(cyc, 1'b0, 2); exp_iss(cyc + 1, 1'b0, 2);
    exp_rsp(cyc + 1, 2, 16'h5006); exp_rsp(cyc + 2, 2, 16'h5006);
    step(); step();
    fetch_req = '0;
    @(negedge clk); check("b2b_rr_ptr", 64'(dut.rr_ptr), 64'(3));
    step(); step();
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("iss_queue_drained", 64'(q_iss.size()), 64'(0));
    check("rsp_queue_drained", 64'(q_rsp.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
